// File: rtl/temporal_pkg.sv
// temporal_pkg: shared types and default constants for the race-logic
// temporal reduction datapath.
//   tmode_e               - reduction mode (MAX = latest arrival, MIN = earliest)
//   GAMMA_CYCLE_WIDTH_DEF - default gamma-cycle length in clock cycles
//   PULSE_WIDTH_DEF       - default output pulse length in clock cycles
package temporal_pkg;

    typedef enum logic {TMODE_MAX, TMODE_MIN} tmode_e;

    localparam int GAMMA_CYCLE_WIDTH_DEF = 16;
    localparam int PULSE_WIDTH_DEF       = 8;

endpackage

// File: rtl/arrival_latch.sv
// arrival_latch: per-channel rising-edge detector with a sticky arrival bit.
//   aclk    - clock
//   grst    - synchronous active-high reset (clears prev_in and arrived)
//   clr     - gamma boundary: clears arrived, leaves prev_in running
//   in_bit  - pulse-coded channel input
//   en_bit  - registered channel enable
//   rise    - first enabled rising edge of this gamma cycle (combinational)
//   arrived - channel has already risen in this gamma cycle
module arrival_latch (
    input  logic aclk,
    input  logic grst,
    input  logic clr,
    input  logic in_bit,
    input  logic en_bit,
    output logic rise,
    output logic arrived
);

    logic prev_in;

    // Only the first rise per gamma cycle is reported; later ones are masked
    // by the sticky bit.
    assign rise = in_bit & ~prev_in & en_bit & ~arrived;

    always_ff @(posedge aclk) begin
        if (grst) begin
            prev_in <= 1'b0;
            arrived <= 1'b0;
        end else begin
            // prev_in keeps tracking across the boundary so a level held
            // high into the next gamma cycle is not seen as a new rise.
            prev_in <= in_bit;
            if (clr)
                arrived <= 1'b0;
            else if (rise)
                arrived <= 1'b1;
        end
    end

endmodule

// File: rtl/temporal_reduce.sv
// temporal_reduce: N-input temporal MAX/MIN reduction over a free-running
// gamma cycle. Emits one PULSE_WIDTH pulse at the decisive arrival time and
// reports that time and the winning channel.
//   aclk      - clock
//   grst      - synchronous active-high reset, also starts a gamma cycle
//   mode      - 0 = MAX, 1 = MIN; sampled on grst and at the gamma boundary
//   en        - per-channel enable; sampled with mode
//   in        - pulse-coded inputs (value = gamma time of rising edge)
//   y         - output pulse
//   out_valid - a winner was decided in the current gamma cycle
//   t_out     - gamma time of the decisive edge
//   win_idx   - winning channel (lowest index among simultaneous rises)
//   gamma_cnt - current position in the gamma cycle
module temporal_reduce
    import temporal_pkg::*;
#(
    parameter int N                 = 4,
    parameter int GAMMA_CYCLE_WIDTH = GAMMA_CYCLE_WIDTH_DEF,
    parameter int PULSE_WIDTH       = PULSE_WIDTH_DEF,
    parameter int TW                = $clog2(GAMMA_CYCLE_WIDTH)
) (
    input  logic                 aclk,
    input  logic                 grst,
    input  logic                 mode,
    input  logic [N-1:0]         en,
    input  logic [N-1:0]         in,
    output logic                 y,
    output logic                 out_valid,
    output logic [TW-1:0]        t_out,
    output logic [$clog2(N)-1:0] win_idx,
    output logic [TW-1:0]        gamma_cnt
);

    localparam int             IW   = $clog2(N);
    localparam int             PCW  = $clog2(PULSE_WIDTH + 1);
    localparam logic [TW-1:0]  LAST = TW'(GAMMA_CYCLE_WIDTH - 1);

    tmode_e         mode_q;
    logic [N-1:0]   en_q;
    logic [N-1:0]   rise;
    logic [N-1:0]   arrived;
    logic [N-1:0]   rise_v;
    logic           boundary;
    logic           covered;
    logic           decide;
    logic           found;
    logic [IW-1:0]  idx;
    logic [PCW-1:0] pcnt;

    assign boundary = (gamma_cnt == LAST);

    for (genvar i = 0; i < N; i++) begin : g_lat
        arrival_latch u_lat (
            .aclk    (aclk),
            .grst    (grst),
            .clr     (boundary),
            .in_bit  (in[i]),
            .en_bit  (en_q[i]),
            .rise    (rise[i]),
            .arrived (arrived[i])
        );
    end

    always_comb begin
        // A rise in the last slot of the gamma cycle encodes infinity.
        rise_v  = boundary ? '0 : rise;
        covered = ((arrived | rise_v) & en_q) == en_q;
        // rise_v is nonzero only for enabled channels, so en_q == 0 never decides.
        decide  = !out_valid && (|rise_v) && ((mode_q == TMODE_MIN) || covered);
        idx     = '0;
        found   = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (rise_v[i] && !found) begin
                idx   = IW'(i);
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (grst) begin
            gamma_cnt <= '0;
            out_valid <= 1'b0;
            t_out     <= '0;
            win_idx   <= '0;
            pcnt      <= '0;
            mode_q    <= tmode_e'(mode);
            en_q      <= en;
        end else begin
            gamma_cnt <= gamma_cnt + TW'(1);
            if (boundary) begin
                out_valid <= 1'b0;
                t_out     <= '0;
                win_idx   <= '0;
                pcnt      <= '0;
                mode_q    <= tmode_e'(mode);
                en_q      <= en;
            end else if (decide) begin
                out_valid <= 1'b1;
                t_out     <= gamma_cnt;
                win_idx   <= idx;
                pcnt      <= PCW'(PULSE_WIDTH);
            end else if (pcnt != '0) begin
                pcnt <= pcnt - PCW'(1);
            end
        end
    end

    // Clearing pcnt at the boundary truncates a late pulse at gamma_cnt = 0.
    assign y = (pcnt != '0);

endmodule

// File: tb/tb_temporal_reduce.sv
// tb_temporal_reduce: randomized and directed self-checking bench for
// temporal_reduce. The reference model records each channel's first-rise
// time per gamma cycle and derives the expected outputs arithmetically.
module tb_temporal_reduce;

    localparam int N  = 4;
    localparam int G  = 16;
    localparam int PW = 8;
    localparam int TW = 4;

    logic          aclk = 1'b0;
    logic          grst;
    logic          mode;
    logic [N-1:0]  en;
    logic [N-1:0]  in;
    logic          y;
    logic          out_valid;
    logic [TW-1:0] t_out;
    logic [1:0]    win_idx;
    logic [TW-1:0] gamma_cnt;

    int checks = 0;
    int errors = 0;

    // reference model state
    int           m_cnt;
    logic         m_mode;
    logic [N-1:0] m_en;
    logic [N-1:0] m_prev;
    int           first_t [N];

    temporal_reduce #(
        .N                 (N),
        .GAMMA_CYCLE_WIDTH (G),
        .PULSE_WIDTH       (PW)
    ) dut (
        .aclk      (aclk),
        .grst      (grst),
        .mode      (mode),
        .en        (en),
        .in        (in),
        .y         (y),
        .out_valid (out_valid),
        .t_out     (t_out),
        .win_idx   (win_idx),
        .gamma_cnt (gamma_cnt)
    );

    always #5 aclk = ~aclk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (model cnt %0d, t=%0t)", tag, got, exp, m_cnt, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs the DUT sees.
    task automatic model_step();
        if (grst) begin
            m_cnt  = 0;
            m_prev = '0;
            for (int i = 0; i < N; i++) first_t[i] = -1;
            m_mode = mode;
            m_en   = en;
        end else begin
            for (int i = 0; i < N; i++)
                if (in[i] && !m_prev[i] && m_en[i] && first_t[i] < 0 && m_cnt != G-1)
                    first_t[i] = m_cnt;
            m_prev = in;
            if (m_cnt == G-1) begin
                m_cnt = 0;
                for (int i = 0; i < N; i++) first_t[i] = -1;
                m_mode = mode;
                m_en   = en;
            end else begin
                m_cnt++;
            end
        end
    endtask

    task automatic check_outputs();
        logic ev;
        logic ey;
        int   d;
        int   ew;
        bit   all_in;
        ev = 1'b0;
        d  = -1;
        if (m_mode) begin
            for (int i = 0; i < N; i++)
                if (m_en[i] && first_t[i] >= 0 && (d < 0 || first_t[i] < d)) d = first_t[i];
            ev = (d >= 0);
        end else begin
            all_in = 1'b1;
            for (int i = 0; i < N; i++)
                if (m_en[i]) begin
                    if (first_t[i] < 0) all_in = 1'b0;
                    else if (first_t[i] > d) d = first_t[i];
                end
            ev = (m_en != '0) && all_in;
        end
        ew = 0;
        if (ev)
            for (int i = N-1; i >= 0; i--)
                if (m_en[i] && first_t[i] == d) ew = i;
        ey = ev && (m_cnt <= d + PW);
        check_eq("gamma_cnt", gamma_cnt, m_cnt);
        check_eq("y",         y,         ey);
        check_eq("out_valid", out_valid, ev);
        check_eq("t_out",     t_out,     ev ? d : 0);
        check_eq("win_idx",   win_idx,   ew);
    endtask

    // One gamma cycle of stimulus: channel i is high once m_cnt >= rt[i].
    // nmode/nen are presented throughout (sampled at the closing boundary);
    // mode inverts from slot flip_at, grst pulses at slot rst_at.
    task automatic run_gamma(input int rt [N], input logic nmode, input logic [N-1:0] nen,
                             input int rst_at, input int flip_at, input bit glitch);
        for (int k = 0; k < G; k++) begin
            @(negedge aclk);
            check_outputs();
            mode = (flip_at >= 0 && k >= flip_at) ? ~nmode : nmode;
            en   = nen;
            grst = (k == rst_at);
            for (int i = 0; i < N; i++) begin
                in[i] = (m_cnt >= rt[i]);
                if (glitch && ($urandom % 12 == 0)) in[i] = ~in[i];
            end
            @(posedge aclk);
            model_step();
        end
    endtask

    initial begin
        int rt [N];
        int ra;
        int fa;
        grst = 1'b1;
        mode = 1'b0;
        en   = '1;
        in   = '0;
        @(posedge aclk);
        model_step();

        // MAX staggered: decision at 5, winner ch2
        rt = '{2, 3, 5, 4};     run_gamma(rt, 1'b1, 4'hF,   -1, -1, 0);
        // MIN simultaneous ch1/ch3 at 7
        rt = '{99, 7, 99, 7};   run_gamma(rt, 1'b0, 4'hF,   -1, -1, 0);
        // MAX with ch2 missing, then ch2 disabled
        rt = '{1, 2, 99, 3};    run_gamma(rt, 1'b0, 4'b1011, -1, -1, 0);
        rt = '{1, 2, 99, 3};    run_gamma(rt, 1'b0, 4'hF,   -1, -1, 0);
        // truncation at 12
        rt = '{3, 1, 5, 12};    run_gamma(rt, 1'b0, 4'hF,   -1, -1, 0);
        // rise in last slot is ignored
        rt = '{2, 3, 15, 4};    run_gamma(rt, 1'b0, 4'hF,   -1, -1, 0);
        // ch0 held high across boundary
        rt = '{0, 1, 1, 1};     run_gamma(rt, 1'b0, 4'hF,   -1, -1, 0);
        // clean low gamma, then mid-pulse reset with earlier mode toggle
        rt = '{99, 99, 99, 99}; run_gamma(rt, 1'b0, 4'hF,   -1, -1, 0);
        rt = '{2, 3, 5, 4};     run_gamma(rt, 1'b0, 4'hF,   10,  4, 0);
        rt = '{2, 3, 5, 4};     run_gamma(rt, 1'b0, 4'hF,   -1, -1, 0);

        for (int g = 0; g < 40; g++) begin
            for (int i = 0; i < N; i++) rt[i] = $urandom_range(0, 19);
            ra = ($urandom % 6 == 0) ? int'($urandom_range(0, G-1)) : -1;
            fa = ($urandom % 4 == 0) ? int'($urandom_range(0, G-1)) : -1;
            run_gamma(rt, 1'($urandom), ($urandom % 3 == 0) ? 4'hF : 4'($urandom), ra, fa, 1);
        end

        @(negedge aclk);
        check_outputs();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
